timer_input_mc: RTL and testbench

Multi-channel successor to the timer's single-input conditioner. It takes `NUM_CH` asynchronous external clock/event inputs and, per channel, applies:
- a configurable-depth synchroniser,
- a stability (glitch) filter,
- a selectable edge detector,
- optional gating by a synchronised `trigger`,
- a per-channel event prescaler.

It emits one-cycle `clk_pulse` strobes that drive the timer counters, and exposes the filtered levels for status readback.

---
 rtl/timer_pkg.sv | 18 +
 rtl/timer_input_mc_if.sv | 34 +++
 rtl/timer_input_chan.sv | 100 ++++++++++
 rtl/timer_input_mc.sv | 71 +++++++
 tb/tb_timer_input_mc.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and defaults for the timer input conditioner.
//   edge_mode_e     : per-channel edge selection (off / rising / falling / both)
//   SYNC_STAGES_DEF : default synchroniser depth for clk_ext and trigger
// ---------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/timer_input_mc_if.sv
// ---------------------------------------------------------------------------
// timer_input_mc_if
// Groups the external inputs, configuration and outputs of timer_input_mc.
//   clk_ext    : NUM_CH asynchronous external clock/event inputs
//   trigger    : asynchronous gate input shared by all channels
//   edge_mode  : 2 bits per channel, [2k+1:2k] (00 off, 01 rise, 10 fall, 11 both)
//   gate_en    : per channel, pass edges only while synchronised trigger is high
//   prescale   : shared, one pulse per (prescale+1) qualified edges
//   clk_pulse  : one-cycle strobe per emitted event
//   level_filt : filtered input level per channel
// master = driver of inputs (timer core / bench), slave = the conditioner.
// ---------------------------------------------------------------------------
interface timer_input_mc_if #(
   parameter int NUM_CH = 4,
   parameter int PS_W   = 8
);
   logic [NUM_CH-1:0]   clk_ext;
   logic                trigger;
   logic [2*NUM_CH-1:0] edge_mode;
   logic [NUM_CH-1:0]   gate_en;
   logic [PS_W-1:0]     prescale;
   logic [NUM_CH-1:0]   clk_pulse;
   logic [NUM_CH-1:0]   level_filt;

   modport master (
      output clk_ext, trigger, edge_mode, gate_en, prescale,
      input  clk_pulse, level_filt
   );

   modport slave (
      input  clk_ext, trigger, edge_mode, gate_en, prescale,
      output clk_pulse, level_filt
   );
endinterface

// File: rtl/timer_input_chan.sv
// ---------------------------------------------------------------------------
// timer_input_chan
// One conditioned input channel: stability filter, edge detect, trigger gate
// and event prescaler, with a registered one-cycle output strobe.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   s           : already-synchronised input level
//   trig_s      : already-synchronised shared trigger
//   mode        : edge selection for this channel
//   gate_en     : 1 = qualify edges only while trig_s is high
//   prescale    : one pulse per (prescale+1) qualified edges
//   clk_pulse   : registered one-cycle event strobe
//   level_filt  : filtered level
// ---------------------------------------------------------------------------
module timer_input_chan
   import timer_pkg::*;
#(
   parameter int FILT_LEN = 4,
   parameter int PS_W     = 8
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s,
   input  logic            trig_s,
   input  edge_mode_e      mode,
   input  logic            gate_en,
   input  logic [PS_W-1:0] prescale,
   output logic            clk_pulse,
   output logic            level_filt
);

   // FILT_LEN = 1 would give a zero-width counter; keep one bit, it never moves.
   localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILT_LEN - 1);

   logic              level_reg, level_next;
   logic              level_d_reg;
   logic [FCNT_W-1:0] fcnt_reg, fcnt_next;
   logic [PS_W-1:0]   pcnt_reg, pcnt_next;
   logic              pulse_reg, pulse_next;

   logic rise, fall, rise_en, fall_en, qual, qual_g;

   // Filter: a new level is accepted only after it has differed from the
   // current one for FILT_LEN consecutive samples; any agreement restarts.
   always_comb begin
      level_next = level_reg;
      fcnt_next  = fcnt_reg;
      if (s == level_reg) begin
         fcnt_next = '0;
      end else if (fcnt_reg == FCNT_MAX) begin
         level_next = s;
         fcnt_next  = '0;
      end else begin
         fcnt_next = fcnt_reg + 1'b1;
      end
   end

   assign rise    = level_reg & ~level_d_reg;
   assign fall    = ~level_reg & level_d_reg;
   assign rise_en = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
   assign fall_en = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
   assign qual    = (rise_en & rise) | (fall_en & fall);
   // Gated-off edges are dropped outright, never held for later.
   assign qual_g  = qual & (~gate_en | trig_s);

   // Prescaler: >= (not ==) so lowering prescale below the running count
   // makes the very next qualified edge emit instead of wrapping.
   always_comb begin
      pcnt_next  = pcnt_reg;
      pulse_next = 1'b0;
      if (qual_g) begin
         if (pcnt_reg >= prescale) begin
            pulse_next = 1'b1;
            pcnt_next  = '0;
         end else begin
            pcnt_next = pcnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_reg   <= 1'b0;
         level_d_reg <= 1'b0;
         fcnt_reg    <= '0;
         pcnt_reg    <= '0;
         pulse_reg   <= 1'b0;
      end else begin
         level_reg   <= level_next;
         level_d_reg <= level_reg;
         fcnt_reg    <= fcnt_next;
         pcnt_reg    <= pcnt_next;
         pulse_reg   <= pulse_next;
      end
   end

   assign clk_pulse  = pulse_reg;
   assign level_filt = level_reg;

endmodule

// File: rtl/timer_input_mc.sv
// ---------------------------------------------------------------------------
// timer_input_mc
// Multi-channel timer input conditioner. Synchronises NUM_CH asynchronous
// inputs and the shared trigger, then runs one timer_input_chan per input.
//   clk    : system clock, all logic on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : timer_input_mc_if slave (clk_ext, trigger, edge_mode, gate_en,
//            prescale in; clk_pulse, level_filt out)
// Parameters: NUM_CH (1..16), SYNC_STAGES (2..4), FILT_LEN (1..255), PS_W.
// The interface instance must use the same NUM_CH and PS_W.
// ---------------------------------------------------------------------------
module timer_input_mc
   import timer_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILT_LEN    = 4,
   parameter int PS_W        = 8
)(
   input logic             clk,
   input logic             rst_n,
   timer_input_mc_if.slave bus
);

   logic [SYNC_STAGES-1:0] trig_sync_reg;
   logic                   trig_s;
   logic [NUM_CH-1:0]      pulse_vec;
   logic [NUM_CH-1:0]      level_vec;

   // Single trigger synchroniser shared by every channel's gate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_sync_reg <= '0;
      end else begin
         trig_sync_reg <= {trig_sync_reg[SYNC_STAGES-2:0], bus.trigger};
      end
   end

   assign trig_s = trig_sync_reg[SYNC_STAGES-1];

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_reg <= '0;
         end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.clk_ext[gi]};
         end
      end

      timer_input_chan #(
         .FILT_LEN (FILT_LEN),
         .PS_W     (PS_W)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .s          (sync_reg[SYNC_STAGES-1]),
         .trig_s     (trig_s),
         .mode       (edge_mode_e'(bus.edge_mode[2*gi +: 2])),
         .gate_en    (bus.gate_en[gi]),
         .prescale   (bus.prescale),
         .clk_pulse  (pulse_vec[gi]),
         .level_filt (level_vec[gi])
      );
   end

   assign bus.clk_pulse  = pulse_vec;
   assign bus.level_filt = level_vec;

endmodule

// File: tb/tb_timer_input_mc.sv
// ---------------------------------------------------------------------------
// tb_timer_input_mc
// Directed self-checking bench for timer_input_mc with default parameters
// (NUM_CH=4, SYNC_STAGES=2, FILT_LEN=4, PS_W=8). Inputs change 1 time unit
// after a rising edge, so the next rising edge is "edge 1"; outputs are
// sampled at the same offset. Pulses are also tallied on the falling edge.
// ---------------------------------------------------------------------------
module tb_timer_input_mc;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   timer_input_mc_if #(.NUM_CH(4), .PS_W(8)) bus ();

   timer_input_mc #(
      .NUM_CH      (4),
      .SYNC_STAGES (2),
      .FILT_LEN    (4),
      .PS_W        (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int pulse_total [4] = '{default: 0};
   int last_pc     [4] = '{default: 0};
   int prev_pc     [4] = '{default: 0};
   int base        [4] = '{default: 0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (bus.clk_pulse[k] === 1'b1) begin
            pulse_total[k] = pulse_total[k] + 1;
            prev_pc[k]     = last_pc[k];
            last_pc[k]     = cyc;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      for (int k = 0; k < 4; k++) base[k] = pulse_total[k];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] val;

      // ---------------- reset ----------------
      bus.clk_ext   = 4'b0000;
      bus.trigger   = 1'b0;
      bus.edge_mode = 8'h00;
      bus.gate_en   = 4'b0000;
      bus.prescale  = 8'd0;
      tick(3);
      check("rst_pulse", 32'(bus.clk_pulse), 32'h0);
      check("rst_level", 32'(bus.level_filt), 32'h0);
      rst_n = 1'b1;
      // ch3 rise, ch2 both, ch1 both, ch0 rise
      bus.edge_mode = 8'b01_11_11_01;
      bus.gate_en   = 4'b1000;
      tick(4);
      check("idle_pulse", 32'(bus.clk_pulse), 32'h0);

      // ---------------- latency, ch0 ----------------
      snap();
      bus.clk_ext[0] = 1'b1;
      tick(5);
      check("t1_level_e5", 32'(bus.level_filt), 32'h0);
      tick(1);
      check("t1_level_e6", 32'(bus.level_filt), 32'h1);
      check("t1_pulse_e6", 32'(bus.clk_pulse), 32'h0);
      tick(1);
      check("t1_pulse_e7", 32'(bus.clk_pulse), 32'h1);
      tick(1);
      check("t1_pulse_e8", 32'(bus.clk_pulse), 32'h0);
      bus.clk_ext[0] = 1'b0;
      tick(10);
      check("t1_cnt_ch0", 32'(pulse_total[0] - base[0]), 32'd1);
      check("t1_cnt_oth", 32'((pulse_total[1] - base[1]) + (pulse_total[2] - base[2])
                              + (pulse_total[3] - base[3])), 32'd0);

      // ---------------- glitch filter, ch1 ----------------
      snap();
      bus.clk_ext[1] = 1'b1;
      tick(3);
      bus.clk_ext[1] = 1'b0;
      tick(10);
      check("t2_glitch_lvl", 32'(bus.level_filt[1]), 32'h0);
      check("t2_glitch_cnt", 32'(pulse_total[1] - base[1]), 32'd0);
      bus.clk_ext[1] = 1'b1;
      tick(4);
      bus.clk_ext[1] = 1'b0;
      tick(3);
      check("t2_rise_pulse", 32'(bus.clk_pulse), 32'h2);
      tick(4);
      check("t2_fall_pulse", 32'(bus.clk_pulse), 32'h2);
      tick(6);
      check("t2_cnt", 32'(pulse_total[1] - base[1]), 32'd2);

      // ---------------- prescaler, ch2 ----------------
      snap();
      bus.prescale = 8'd2;
      for (int i = 0; i < 6; i++) begin
         bus.clk_ext[2] = ~bus.clk_ext[2];
         tick(8);
      end
      check("t3_cnt6", 32'(pulse_total[2] - base[2]), 32'd2);
      check("t3_interval", 32'(last_pc[2] - prev_pc[2]), 32'd24);
      for (int i = 0; i < 2; i++) begin
         bus.clk_ext[2] = ~bus.clk_ext[2];
         tick(8);
      end
      check("t3_cnt8", 32'(pulse_total[2] - base[2]), 32'd2);
      bus.prescale   = 8'd0;
      bus.clk_ext[2] = ~bus.clk_ext[2];
      tick(10);
      check("t3_lowered", 32'(pulse_total[2] - base[2]), 32'd3);

      // ---------------- trigger gate, ch3 ----------------
      snap();
      for (int i = 0; i < 3; i++) begin
         bus.clk_ext[3] = 1'b1;
         tick(8);
         bus.clk_ext[3] = 1'b0;
         tick(8);
      end
      check("t4_gated_off", 32'(pulse_total[3] - base[3]), 32'd0);
      bus.trigger = 1'b1;
      tick(4);
      for (int i = 0; i < 3; i++) begin
         bus.clk_ext[3] = 1'b1;
         tick(8);
         bus.clk_ext[3] = 1'b0;
         tick(8);
      end
      check("t4_gated_on", 32'(pulse_total[3] - base[3]), 32'd3);

      // ---------------- reset mid-filter / mid-prescale ----------------
      snap();
      bus.prescale   = 8'd1;
      bus.clk_ext[0] = 1'b1;
      bus.clk_ext[3] = 1'b1;
      tick(10);
      check("t5_pre_cnt", 32'(pulse_total[0] - base[0] + pulse_total[3] - base[3]), 32'd0);
      bus.clk_ext[0] = 1'b0;
      tick(10);
      bus.clk_ext[0] = 1'b1;
      tick(3);
      check("t5_pre_level", 32'(bus.level_filt), 32'hC);
      rst_n = 1'b0;
      #2;
      check("t5_async_lvl", 32'(bus.level_filt), 32'h0);
      check("t5_async_pls", 32'(bus.clk_pulse), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check("t5_rel_e5", 32'(bus.level_filt), 32'h0);
      tick(1);
      check("t5_rel_e6", 32'(bus.level_filt), 32'hD);
      tick(1);
      check("t5_restart_e7", 32'(bus.clk_pulse), 32'h0);
      bus.clk_ext[0] = 1'b0;
      tick(12);
      bus.clk_ext[0] = 1'b1;
      tick(7);
      check("t5_second_e7", 32'(bus.clk_pulse), 32'h1);
      tick(1);
      check("t5_second_e8", 32'(bus.clk_pulse), 32'h0);

      // ---------------- mode 00 everywhere ----------------
      snap();
      bus.edge_mode = 8'h00;
      bus.prescale  = 8'd0;
      for (int i = 0; i < 6; i++) begin
         val = 4'($urandom_range(0, 15));
         bus.clk_ext = val;
         tick(7);
         check($sformatf("t6_level_%0d", i), 32'(bus.level_filt), 32'(val));
      end
      check("t6_no_pulse", 32'((pulse_total[0] - base[0]) + (pulse_total[1] - base[1])
                               + (pulse_total[2] - base[2]) + (pulse_total[3] - base[3])), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
